// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
//   state_t   : arbiter FSM states
//   PORT_*    : requester indices used for rr_last / owner / one-hot grants
//   LAT_MAX   : largest supported read latency
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LDR  = 1'b1;

  localparam int unsigned LAT_MAX = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational. The caller owns the
// "last granted" register and updates it from win_o when a grant is taken.
//   req_i   : request vector, bit PORT_CORE / PORT_LDR
//   last_i  : index of the most recently granted port
//   gnt_o   : one-hot grant (all zero when no request)
//   win_o   : index of the winner (only meaningful when valid_o)
//   valid_o : at least one request present
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       win_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    // On contention the port that did not win last time goes first.
    if (&req_i) begin
      win_o = ~last_i;
    end else if (req_i[PORT_LDR]) begin
      win_o = PORT_LDR;
    end else begin
      win_o = PORT_CORE;
    end
    gnt_o = 2'b00;
    if (valid_o) begin
      gnt_o[win_o] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single unified memory port shared by the core and the
// program loader/DMA. Writes complete in the grant cycle; reads occupy the
// port for LAT further cycles and return data through the owner's rvalid.
//   CLK, Reset                  : clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata   : core request (held until c_gnt)
//   c_gnt/c_rvalid/c_rdata      : core accept, read-data strobe and data
//   l_*                         : same for the loader
//   m_en/m_we/m_addr/m_wdata    : memory macro command
//   m_rdata                     : memory read data, LAT cycles after a read
//   busy                        : a read is in flight
// LAT must lie in 1..LAT_MAX.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  localparam int unsigned CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LatCnt = CW'(LAT);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_last_q, rr_last_d;
  logic          owner_q, owner_d;

  logic [1:0] arb_gnt;
  logic       arb_win;
  logic       arb_valid;
  logic       sel_we;
  logic       issue;
  logic       rv;
  logic       live;

  rr_arb2 u_rr_arb2 (
    .req_i   ({l_req, c_req}),
    .last_i  (rr_last_q),
    .gnt_o   (arb_gnt),
    .win_o   (arb_win),
    .valid_o (arb_valid)
  );

  // Command mux follows the arbiter winner; only m_en/m_we qualify it.
  always_comb begin
    sel_we  = (arb_win == PORT_LDR) ? l_we    : c_we;
    m_addr  = (arb_win == PORT_LDR) ? l_addr  : c_addr;
    m_wdata = (arb_win == PORT_LDR) ? l_wdata : c_wdata;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    issue     = 1'b0;
    rv        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          issue     = 1'b1;
          rr_last_d = arb_win;
          if (!sel_we) begin
            state_d = WAIT;
            cnt_d   = CW'(1);
            owner_d = arb_win;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LatCnt) begin
          rv      = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Nothing may leave the block while Reset is high, even before the
  // registers have been cleared by the first reset edge.
  assign live     = ~Reset;
  assign m_en     = issue & live;
  assign m_we     = m_en & sel_we;
  assign c_gnt    = m_en & arb_gnt[PORT_CORE];
  assign l_gnt    = m_en & arb_gnt[PORT_LDR];
  assign c_rvalid = rv & live & (owner_q == PORT_CORE);
  assign l_rvalid = rv & live & (owner_q == PORT_LDR);
  assign c_rdata  = m_rdata;
  assign l_rdata  = m_rdata;
  assign busy     = (state_q == WAIT) & live;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_last_q <= PORT_LDR;
      owner_q   <= PORT_CORE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Three instances: LAT=2 (directed scenarios),
// LAT=1 and LAT=8 (random sweeps against a timing/scoreboard model).
module tb_mem_port_arbiter;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [NI-1:0]       Reset;
  logic [NI-1:0]       c_req, c_we, c_gnt, c_rvalid;
  logic [NI-1:0]       l_req, l_we, l_gnt, l_rvalid;
  logic [NI-1:0]       m_en, m_we, busy;
  logic [NI-1:0][31:0] c_addr, c_wdata, c_rdata;
  logic [NI-1:0][31:0] l_addr, l_wdata, l_rdata;
  logic [NI-1:0][31:0] m_addr, m_wdata, m_rdata;

  int nvec = 0;
  int nerr = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(
      .AW  (32),
      .DW  (32),
      .LAT (lat_of(g))
    ) u_dut (
      .CLK      (CLK),
      .Reset    (Reset[g]),
      .c_req    (c_req[g]),
      .c_we     (c_we[g]),
      .c_addr   (c_addr[g]),
      .c_wdata  (c_wdata[g]),
      .c_gnt    (c_gnt[g]),
      .c_rvalid (c_rvalid[g]),
      .c_rdata  (c_rdata[g]),
      .l_req    (l_req[g]),
      .l_we     (l_we[g]),
      .l_addr   (l_addr[g]),
      .l_wdata  (l_wdata[g]),
      .l_gnt    (l_gnt[g]),
      .l_rvalid (l_rvalid[g]),
      .l_rdata  (l_rdata[g]),
      .m_en     (m_en[g]),
      .m_we     (m_we[g]),
      .m_addr   (m_addr[g]),
      .m_wdata  (m_wdata[g]),
      .m_rdata  (m_rdata[g]),
      .busy     (busy[g])
    );
  end

  // ---------------- memory macro model (per instance) ----------------
  int          cyc = 0;
  logic [31:0] mem   [NI][256];
  bit          mem_v [NI][256];
  logic [31:0] pd    [NI] = '{32'h0, 32'h0, 32'h0};
  int          due   [NI] = '{-1, -1, -1};

  function automatic logic [31:0] init_val(input int k, input logic [7:0] idx);
    if (idx == 8'h40) return 32'hDEADBEEF;
    return 32'h5A000000 ^ (32'(k) << 20) ^ ({24'h0, idx} * 32'h00010101);
  endfunction

  function automatic logic [31:0] mem_read(input int k, input logic [7:0] idx);
    return mem_v[k][idx] ? mem[k][idx] : init_val(k, idx);
  endfunction

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NI; k++) begin
      if (m_en[k] && !m_we[k]) begin
        pd[k]  <= mem_read(k, m_addr[k][9:2]);
        due[k] <= cyc + lat_of(k);
      end
      if (m_en[k] && m_we[k]) begin
        mem[k][m_addr[k][9:2]]   <= m_wdata[k];
        mem_v[k][m_addr[k][9:2]] <= 1'b1;
      end
    end
  end

  always_comb begin
    m_rdata = '0;
    for (int k = 0; k < NI; k++) begin
      m_rdata[k] = (cyc == due[k]) ? pd[k] : 32'h0BAD0BAD;
    end
  end

  // ---------------- helpers ----------------
  // {c_gnt, l_gnt, m_en, m_we, c_rvalid, l_rvalid, busy}
  function automatic logic [6:0] flags(input int k);
    return {c_gnt[k], l_gnt[k], m_en[k], m_we[k], c_rvalid[k], l_rvalid[k], busy[k]};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic clear_inputs(input int k);
    c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
    l_req[k] = 1'b0; l_we[k] = 1'b0; l_addr[k] = '0; l_wdata[k] = '0;
  endtask

  task automatic do_reset(input int k);
    Reset[k] = 1'b1;
    clear_inputs(k);
    step();
    step();
    Reset[k] = 1'b0;
  endtask

  // ---------------- directed scenarios on LAT=2 ----------------
  task automatic test_reset();
    Reset[0] = 1'b1;
    c_req[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 32'h200; c_wdata[0] = 32'h11111111;
    l_req[0] = 1'b1; l_we[0] = 1'b1; l_addr[0] = 32'h204; l_wdata[0] = 32'h22222222;
    step();
    sample();
    nvec++;
    if (flags(0) !== 7'b0000000) begin
      nerr++; $display("FAIL reset_gating flags: got %b want %b", flags(0), 7'b0000000);
    end
    step();
    Reset[0] = 1'b0;
    sample();
    nvec++;
    if (flags(0) !== 7'b1011000) begin
      nerr++; $display("FAIL reset_first_tie flags: got %b want %b", flags(0), 7'b1011000);
    end
    nvec++;
    if (m_addr[0] !== 32'h200 || m_wdata[0] !== 32'h11111111) begin
      nerr++; $display("FAIL reset_first_tie cmd: got %h/%h want %h/%h",
                       m_addr[0], m_wdata[0], 32'h200, 32'h11111111);
    end
    step();
    c_req[0] = 1'b0;
    sample();
    nvec++;
    if (flags(0) !== 7'b0111000 || m_addr[0] !== 32'h204) begin
      nerr++; $display("FAIL reset_second_ldr flags/addr: got %b/%h want %b/%h",
                       flags(0), m_addr[0], 7'b0111000, 32'h204);
    end
    step();
    l_req[0] = 1'b0;
    sample();
    nvec++;
    if (flags(0) !== 7'b0000000) begin
      nerr++; $display("FAIL reset_idle flags: got %b want %b", flags(0), 7'b0000000);
    end
    step();
  endtask

  task automatic test_core_read();
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h100;
    sample();
    nvec++;
    if (flags(0) !== 7'b1010000 || m_addr[0] !== 32'h100) begin
      nerr++; $display("FAIL core_read_gnt flags/addr: got %b/%h want %b/%h",
                       flags(0), m_addr[0], 7'b1010000, 32'h100);
    end
    step();
    c_req[0] = 1'b0;
    sample();
    nvec++;
    if (flags(0) !== 7'b0000001) begin
      nerr++; $display("FAIL core_read_wait flags: got %b want %b", flags(0), 7'b0000001);
    end
    step();
    sample();
    nvec++;
    if (flags(0) !== 7'b0000101 || c_rdata[0] !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL core_read_rvalid flags/data: got %b/%h want %b/%h",
                       flags(0), c_rdata[0], 7'b0000101, 32'hDEADBEEF);
    end
    step();
    sample();
    nvec++;
    if (flags(0) !== 7'b0000000) begin
      nerr++; $display("FAIL core_read_done flags: got %b want %b", flags(0), 7'b0000000);
    end
    step();
  endtask

  task automatic test_rr_reads();
    logic [31:0] ca, la, ga;
    logic [6:0]  ef;
    logic        core_turn;
    int          ph;
    do_reset(0);
    ca = 32'h10; la = 32'h20; ga = '0;
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = ca;
    l_req[0] = 1'b1; l_we[0] = 1'b0; l_addr[0] = la;
    for (int i = 0; i < 12; i++) begin
      ph        = i % 3;
      core_turn = ((i / 3) % 2) == 0;
      sample();
      if (ph == 0) begin
        ef = core_turn ? 7'b1010000 : 7'b0110000;
        ga = core_turn ? ca : la;
        nvec++;
        if (flags(0) !== ef || m_addr[0] !== ga) begin
          nerr++; $display("FAIL rr_grant[%0d] flags/addr: got %b/%h want %b/%h",
                           i, flags(0), m_addr[0], ef, ga);
        end
      end else if (ph == 1) begin
        nvec++;
        if (flags(0) !== 7'b0000001) begin
          nerr++; $display("FAIL rr_wait[%0d] flags: got %b want %b", i, flags(0), 7'b0000001);
        end
      end else begin
        ef = core_turn ? 7'b0000101 : 7'b0000011;
        nvec++;
        if (flags(0) !== ef ||
            (core_turn ? c_rdata[0] : l_rdata[0]) !== init_val(0, ga[9:2])) begin
          nerr++; $display("FAIL rr_rvalid[%0d] flags/data: got %b/%h want %b/%h", i, flags(0),
                           core_turn ? c_rdata[0] : l_rdata[0], ef, init_val(0, ga[9:2]));
        end
      end
      step();
      if (ph == 0) begin
        if (core_turn) begin
          ca = ca + 32'h4; c_addr[0] = ca;
        end else begin
          la = la + 32'h4; l_addr[0] = la;
        end
      end
      if (i == 11) begin
        c_req[0] = 1'b0; l_req[0] = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd [4];
    l_req[0] = 1'b1; l_we[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd[i]      = $urandom;
      l_addr[0]  = 32'(4 * i);
      l_wdata[0] = wd[i];
      sample();
      nvec++;
      if (flags(0) !== 7'b0111000 || m_addr[0] !== 32'(4 * i) || m_wdata[0] !== wd[i]) begin
        nerr++; $display("FAIL b2b_write[%0d] flags/addr/data: got %b/%h/%h want %b/%h/%h", i,
                         flags(0), m_addr[0], m_wdata[0], 7'b0111000, 32'(4 * i), wd[i]);
      end
      step();
    end
    l_req[0] = 1'b0; l_we[0] = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (mem_read(0, 8'(i)) !== wd[i]) begin
        nerr++; $display("FAIL b2b_mem[%0d]: got %h want %h", i, mem_read(0, 8'(i)), wd[i]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h30;
    sample();
    nvec++;
    if (flags(0) !== 7'b1010000) begin
      nerr++; $display("FAIL rst_wait_gnt flags: got %b want %b", flags(0), 7'b1010000);
    end
    step();
    c_req[0] = 1'b0;
    Reset[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      nvec++;
      if (flags(0) !== 7'b0000000) begin
        nerr++; $display("FAIL rst_wait_hold[%0d] flags: got %b want %b", i, flags(0), 7'b0);
      end
      step();
    end
    Reset[0] = 1'b0;
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h34;
    l_req[0] = 1'b1; l_we[0] = 1'b0; l_addr[0] = 32'h38;
    sample();
    nvec++;
    if (flags(0) !== 7'b1010000 || m_addr[0] !== 32'h34) begin
      nerr++; $display("FAIL rst_wait_core_first flags/addr: got %b/%h want %b/%h",
                       flags(0), m_addr[0], 7'b1010000, 32'h34);
    end
    step();
    c_req[0] = 1'b0;
    sample();
    nvec++;
    if (flags(0) !== 7'b0000001) begin
      nerr++; $display("FAIL rst_wait_w1 flags: got %b want %b", flags(0), 7'b0000001);
    end
    step();
    sample();
    nvec++;
    if (flags(0) !== 7'b0000101 || c_rdata[0] !== init_val(0, 8'h0D)) begin
      nerr++; $display("FAIL rst_wait_c_rvalid flags/data: got %b/%h want %b/%h",
                       flags(0), c_rdata[0], 7'b0000101, init_val(0, 8'h0D));
    end
    step();
    sample();
    nvec++;
    if (flags(0) !== 7'b0110000 || m_addr[0] !== 32'h38) begin
      nerr++; $display("FAIL rst_wait_ldr_next flags/addr: got %b/%h want %b/%h",
                       flags(0), m_addr[0], 7'b0110000, 32'h38);
    end
    step();
    l_req[0] = 1'b0;
    step();
    sample();
    nvec++;
    if (flags(0) !== 7'b0000011 || l_rdata[0] !== init_val(0, 8'h0E)) begin
      nerr++; $display("FAIL rst_wait_l_rvalid flags/data: got %b/%h want %b/%h",
                       flags(0), l_rdata[0], 7'b0000011, init_val(0, 8'h0E));
    end
    step();
  endtask

  task automatic test_write_during_wait();
    l_req[0] = 1'b1; l_we[0] = 1'b0; l_addr[0] = 32'h40;
    sample();
    nvec++;
    if (flags(0) !== 7'b0110000) begin
      nerr++; $display("FAIL wdw_ldr_gnt flags: got %b want %b", flags(0), 7'b0110000);
    end
    step();
    l_req[0] = 1'b0;
    c_req[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 32'h44; c_wdata[0] = 32'hCAFEF00D;
    sample();
    nvec++;
    if (flags(0) !== 7'b0000001) begin
      nerr++; $display("FAIL wdw_no_gnt_w1 flags: got %b want %b", flags(0), 7'b0000001);
    end
    step();
    sample();
    nvec++;
    if (flags(0) !== 7'b0000011 || l_rdata[0] !== init_val(0, 8'h10)) begin
      nerr++; $display("FAIL wdw_l_rvalid flags/data: got %b/%h want %b/%h",
                       flags(0), l_rdata[0], 7'b0000011, init_val(0, 8'h10));
    end
    step();
    sample();
    nvec++;
    if (flags(0) !== 7'b1011000 || m_addr[0] !== 32'h44 || m_wdata[0] !== 32'hCAFEF00D) begin
      nerr++; $display("FAIL wdw_core_write flags/addr/data: got %b/%h/%h want %b/%h/%h",
                       flags(0), m_addr[0], m_wdata[0], 7'b1011000, 32'h44, 32'hCAFEF00D);
    end
    step();
    c_req[0] = 1'b0; c_we[0] = 1'b0;
    sample();
    nvec++;
    if (flags(0) !== 7'b0000000) begin
      nerr++; $display("FAIL wdw_idle flags: got %b want %b", flags(0), 7'b0000000);
    end
    step();
  endtask

  // ---------------- random sweep against a timing model ----------------
  // The model tracks only when the port is next free, who goes first on a
  // tie, when the pending read returns, and a shadow copy of memory.
  logic [31:0] shadow [256];

  task automatic test_sweep(input int k, input int ncyc);
    int          t, free_at, rv_due, lat;
    logic        last, rv_owner, win, egnt, ewe, erv, ebusy;
    logic [31:0] rv_data, got;
    logic        preq [2];
    logic        pwe  [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [6:0]  ef;
    lat = lat_of(k);
    do_reset(k);
    for (int i = 0; i < 256; i++) shadow[i] = init_val(k, 8'(i));
    t = 0; free_at = 0; rv_due = -1; last = 1'b1; rv_owner = 1'b0; rv_data = '0;
    for (int p = 0; p < 2; p++) begin
      preq[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = '0; pwdata[p] = '0;
    end
    for (int n = 0; n < ncyc; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!preq[p] && $urandom_range(0, 1) == 1) begin
          preq[p]   = 1'b1;
          pwe[p]    = 1'($urandom_range(0, 1));
          paddr[p]  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
          pwdata[p] = $urandom;
        end
      end
      c_req[k] = preq[0]; c_we[k] = pwe[0]; c_addr[k] = paddr[0]; c_wdata[k] = pwdata[0];
      l_req[k] = preq[1]; l_we[k] = pwe[1]; l_addr[k] = paddr[1]; l_wdata[k] = pwdata[1];
      sample();
      egnt  = (preq[0] || preq[1]) && (t >= free_at);
      win   = (preq[0] && preq[1]) ? ~last : preq[1];
      ewe   = egnt && pwe[win];
      erv   = (t == rv_due);
      ebusy = (t <= rv_due) && (t > rv_due - lat);
      ef    = {egnt && !win, egnt && win, egnt, ewe, erv && !rv_owner, erv && rv_owner, ebusy};
      nvec++;
      if (flags(k) !== ef) begin
        nerr++; $display("FAIL sweep_lat%0d t=%0d flags: got %b want %b", lat, t, flags(k), ef);
      end
      nvec++;
      if (((c_gnt[k] | l_gnt[k]) & (c_rvalid[k] | l_rvalid[k])) ||
          (c_gnt[k] & l_gnt[k]) || (c_rvalid[k] & l_rvalid[k])) begin
        nerr++; $display("FAIL sweep_lat%0d t=%0d exclusive: got %b want at most one", lat, t,
                         flags(k));
      end
      if (egnt) begin
        nvec++;
        if (m_addr[k] !== paddr[win] || (ewe && m_wdata[k] !== pwdata[win])) begin
          nerr++; $display("FAIL sweep_lat%0d t=%0d cmd: got %h/%h want %h/%h", lat, t,
                           m_addr[k], m_wdata[k], paddr[win], pwdata[win]);
        end
      end
      if (erv) begin
        got = rv_owner ? l_rdata[k] : c_rdata[k];
        nvec++;
        if (got !== rv_data) begin
          nerr++; $display("FAIL sweep_lat%0d t=%0d rdata: got %h want %h", lat, t, got, rv_data);
        end
      end
      if (egnt) begin
        last = win;
        if (ewe) begin
          shadow[paddr[win][9:2]] = pwdata[win];
        end else begin
          rv_due   = t + lat;
          rv_owner = win;
          rv_data  = shadow[paddr[win][9:2]];
          free_at  = t + lat + 1;
        end
        preq[win] = 1'b0;
      end
      t++;
      step();
    end
    clear_inputs(k);
    for (int i = 0; i < lat + 2; i++) step();
  endtask

  initial begin
    Reset = '1;
    for (int k = 0; k < NI; k++) clear_inputs(k);
    test_reset();
    test_core_read();
    test_rr_reads();
    test_back_to_back();
    test_reset_in_wait();
    test_write_during_wait();
    test_sweep(1, 300);
    test_sweep(2, 300);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
